// File: rtl/vga_sram_line_fetcher.sv
// VGA pixel source: prefetches each image line from SRAM into a small word FIFO
// and unpacks packed-RGB24 or RGB565 pixels into registered VGA colour.
module vga_sram_line_fetcher #(
  parameter int unsigned IMG_WIDTH    = 320,
  parameter int unsigned IMG_HEIGHT   = 240,
  parameter int unsigned VIEW_LEFT    = 160,
  parameter int unsigned VIEW_TOP     = 120,
  parameter int unsigned SRAM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        VGA_enable,
  input  logic        pixel_strobe,
  input  logic [9:0]  pixel_X_pos,
  input  logic [9:0]  pixel_Y_pos,
  input  logic        format_mode,
  input  logic [17:0] SRAM_base_address,
  input  logic        SRAM_grant,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  VGA_red,
  output logic [7:0]  VGA_green,
  output logic [7:0]  VGA_blue,
  output logic        underflow
);

  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned SW       = $clog2(FIFO_DEPTH + SRAM_LATENCY + 1);
  localparam int unsigned RW       = $clog2(3 * IMG_WIDTH / 2 + 1);
  localparam logic [17:0] WPL24    = 18'(3 * IMG_WIDTH / 2);
  localparam logic [17:0] WPL565   = 18'(IMG_WIDTH);
  localparam logic [9:0]  TOP_Y    = 10'(VIEW_TOP);
  localparam logic        LEFT_ODD = 1'(VIEW_LEFT % 2);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t r_state, w_next_state;

  logic                    r_mode;
  logic [17:0]             r_issue_addr;
  logic [RW-1:0]           r_remaining;
  logic [SRAM_LATENCY-1:0] r_vld, w_vld_next;
  logic [15:0]             r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]           r_count;

  logic          w_in_lines, w_in_view, w_line_start, w_consume, w_odd;
  logic          w_border, w_line_done, w_issue, w_push, w_short;
  logic [9:0]    w_row;
  logic [17:0]   w_wpl, w_line_addr;
  logic [SW-1:0] w_in_flight;
  logic [1:0]    w_pop;
  logic [15:0]   w_head, w_next;
  logic [23:0]   w_pix, w_colour;

  assign w_in_lines   = (32'(pixel_Y_pos) >= VIEW_TOP) &&
                        (32'(pixel_Y_pos) <  VIEW_TOP + IMG_HEIGHT);
  assign w_in_view    = w_in_lines && (32'(pixel_X_pos) >= VIEW_LEFT) &&
                        (32'(pixel_X_pos) < VIEW_LEFT + IMG_WIDTH);
  assign w_line_start = pixel_strobe && w_in_lines && (32'(pixel_X_pos) == VIEW_LEFT - 16);
  assign w_line_done  = 32'(pixel_X_pos) >= VIEW_LEFT + IMG_WIDTH;
  assign w_consume    = pixel_strobe && w_in_view;
  assign w_odd        = pixel_X_pos[0] ^ LEFT_ODD;
  assign w_border     = (pixel_X_pos == 10'd0) || (pixel_X_pos == 10'd639) ||
                        (pixel_Y_pos == 10'd0) || (pixel_Y_pos == 10'd479);

  assign w_wpl       = format_mode ? WPL565 : WPL24;
  assign w_row       = pixel_Y_pos - TOP_Y;
  assign w_line_addr = SRAM_base_address + 18'(w_row) * w_wpl;

  assign w_head = r_mem[r_rd_ptr];
  assign w_next = r_mem[r_rd_ptr + PW'(1)];
  assign w_push = r_vld[SRAM_LATENCY-1];

  // Words already requested count against FIFO space so it can never overflow.
  always_comb begin
    w_in_flight = '0;
    for (int unsigned i = 0; i < SRAM_LATENCY; i++)
      w_in_flight = w_in_flight + SW'(r_vld[i]);
  end

  assign w_issue = (r_state == S_FETCH) && SRAM_grant && (r_remaining != '0) &&
                   ((SW'(r_count) + w_in_flight) < SW'(FIFO_DEPTH)) && !w_line_start;

  always_comb begin
    w_vld_next    = r_vld << 1;
    w_vld_next[0] = w_issue;
  end

  always_comb begin
    w_pop   = 2'd0;
    w_short = 1'b0;
    w_pix   = '0;
    if (w_consume) begin
      if (r_mode) begin
        if (r_count != '0) begin
          w_pix = {w_head[15:11], w_head[15:13], w_head[10:5], w_head[10:9],
                   w_head[4:0], w_head[4:2]};
          w_pop = 2'd1;
        end else begin
          w_short = 1'b1;
        end
      end else if (r_count >= CW'(2)) begin
        if (!w_odd) begin
          w_pix = {w_head, w_next[15:8]};
          w_pop = 2'd1;
        end else begin
          w_pix = {w_head[7:0], w_next};
          w_pop = 2'd2;
        end
      end else begin
        w_short = 1'b1;
      end
    end
  end

  always_comb begin
    w_colour = '0;
    if (!VGA_enable)    w_colour = 24'h3F3F3F;
    else if (w_border)  w_colour = 24'hFFFFFF;
    else if (w_in_view) w_colour = w_pix;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = S_IDLE;
      S_FETCH: if (r_remaining == '0) w_next_state = S_DRAIN;
      S_DRAIN: if (w_line_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if (w_line_start) w_next_state = S_FETCH;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wr_ptr] <= SRAM_read_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_mode       <= 1'b0;
      r_issue_addr <= '0;
      r_remaining  <= '0;
      r_vld        <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      SRAM_address <= '0;
      VGA_red      <= '0;
      VGA_green    <= '0;
      VGA_blue     <= '0;
      underflow    <= 1'b0;
    end else begin
      // A line start discards leftovers and any reads still in flight.
      if (w_line_start) begin
        r_mode       <= format_mode;
        r_issue_addr <= w_line_addr;
        r_remaining  <= RW'(w_wpl);
        r_vld        <= '0;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_count      <= '0;
      end else begin
        r_vld <= w_vld_next;
        if (w_issue) begin
          r_issue_addr <= r_issue_addr + 18'd1;
          r_remaining  <= r_remaining - RW'(1);
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rd_ptr <= r_rd_ptr + PW'(w_pop);
        r_count  <= r_count + CW'(w_push) - CW'(w_pop);
      end
      if (w_issue) SRAM_address <= r_issue_addr;
      if (pixel_strobe) begin
        VGA_red   <= w_colour[23:16];
        VGA_green <= w_colour[15:8];
        VGA_blue  <= w_colour[7:0];
      end
      if (w_short) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_sram_line_fetcher.sv
// Self-checking bench for vga_sram_line_fetcher: queue-based reference model,
// behavioural SRAM, randomized grant/format/base plus directed line scenarios.
module tb_vga_sram_line_fetcher;

  localparam int IW    = 320;
  localparam int IH    = 240;
  localparam int VL    = 160;
  localparam int VT    = 120;
  localparam int LAT   = 2;
  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        VGA_enable;
  logic        pixel_strobe;
  logic [9:0]  pixel_X_pos;
  logic [9:0]  pixel_Y_pos;
  logic        format_mode;
  logic [17:0] SRAM_base_address;
  logic        SRAM_grant;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [7:0]  VGA_red, VGA_green, VGA_blue;
  logic        underflow;

  vga_sram_line_fetcher #(
    .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .VIEW_LEFT(VL), .VIEW_TOP(VT),
    .SRAM_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clock(Clock), .Reset(Reset), .VGA_enable(VGA_enable), .pixel_strobe(pixel_strobe),
    .pixel_X_pos(pixel_X_pos), .pixel_Y_pos(pixel_Y_pos), .format_mode(format_mode),
    .SRAM_base_address(SRAM_base_address), .SRAM_grant(SRAM_grant),
    .SRAM_address(SRAM_address), .SRAM_read_data(SRAM_read_data),
    .VGA_red(VGA_red), .VGA_green(VGA_green), .VGA_blue(VGA_blue), .underflow(underflow)
  );

  always #5 Clock = ~Clock;

  // Behavioural SRAM: contents are a function of the address, chosen by mem_kind.
  int unsigned mem_kind = 0;
  logic [17:0] apipe [LAT-1];

  function automatic logic [15:0] mem_word(input int unsigned kind, input logic [17:0] a);
    int unsigned v;
    case (kind)
      0:       v = int'(a);
      1:       v = 32'h1122 + (int'(a) - 32'h100) * 32'h2222;
      default: v = (int'(a) * 40503) ^ (int'(a) >> 5) ^ 32'hA5C3;
    endcase
    return v[15:0];
  endfunction

  function automatic logic [23:0] rgb565(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

  always @(posedge Clock) begin
    apipe[0] <= SRAM_address;
    for (int i = 1; i < LAT - 1; i++) apipe[i] <= apipe[i-1];
  end
  assign SRAM_read_data = mem_word(mem_kind, apipe[LAT-2]);

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0]  m_fifo[$];
  logic [15:0]  m_infl_w[$];
  int unsigned  m_infl_due[$];
  int unsigned  m_cyc = 0;
  logic         m_mode;
  logic [17:0]  m_addr;
  int           m_rem;
  logic [17:0]  e_addr;
  logic [23:0]  e_rgb;
  logic         e_uf;

  task automatic model_step();
    int x, y, k, need, npop, wpl;
    logic in_lines, in_view, ls, short_f, issue;
    logic [15:0] w0, w1;
    logic [23:0] pix;
    if (Reset) begin
      m_fifo.delete(); m_infl_w.delete(); m_infl_due.delete();
      m_mode = 1'b0; m_addr = '0; m_rem = 0;
      e_addr = '0; e_rgb = '0; e_uf = 1'b0;
      m_cyc++;
      return;
    end
    x = int'(pixel_X_pos);
    y = int'(pixel_Y_pos);
    in_lines = (y >= VT) && (y < VT + IH);
    in_view  = in_lines && (x >= VL) && (x < VL + IW);
    ls       = pixel_strobe && in_lines && (x == VL - 16);
    short_f = 1'b0; npop = 0; pix = '0; w0 = '0; w1 = '0;
    if (pixel_strobe && in_view) begin
      k    = x - VL;
      need = m_mode ? 1 : 2;
      if (m_fifo.size() < need) short_f = 1'b1;
      else begin
        w0 = m_fifo[0];
        if (m_mode) begin
          pix = rgb565(w0); npop = 1;
        end else begin
          w1 = m_fifo[1];
          if (k % 2 == 0) begin pix = {w0, w1[15:8]}; npop = 1; end
          else            begin pix = {w0[7:0], w1};  npop = 2; end
        end
      end
    end
    issue = !ls && (m_rem > 0) && SRAM_grant && (m_fifo.size() + m_infl_w.size() < DEPTH);
    if (ls) begin
      m_fifo.delete(); m_infl_w.delete(); m_infl_due.delete();
      m_mode = format_mode;
      wpl    = format_mode ? IW : 3 * IW / 2;
      m_addr = 18'(int'(SRAM_base_address) + (y - VT) * wpl);
      m_rem  = wpl;
    end else begin
      for (int i = 0; i < npop; i++) void'(m_fifo.pop_front());
      if (m_infl_due.size() > 0 && m_infl_due[0] == m_cyc) begin
        m_fifo.push_back(m_infl_w.pop_front());
        void'(m_infl_due.pop_front());
      end
      if (issue) begin
        m_infl_w.push_back(mem_word(mem_kind, m_addr));
        m_infl_due.push_back(m_cyc + LAT);
        e_addr = m_addr;
        m_addr = m_addr + 18'd1;
        m_rem--;
      end
    end
    if (pixel_strobe) begin
      if (!VGA_enable)                                  e_rgb = 24'h3F3F3F;
      else if (x == 0 || x == 639 || y == 0 || y == 479) e_rgb = 24'hFFFFFF;
      else if (in_view)                                 e_rgb = pix;
      else                                              e_rgb = 24'h000000;
    end
    if (short_f) e_uf = 1'b1;
    m_cyc++;
  endtask

  task automatic clk_step();
    model_step();
    @(posedge Clock);
    #1;
    check("addr", 32'(SRAM_address), 32'(e_addr));
    check("rgb_uf", {7'd0, VGA_red, VGA_green, VGA_blue, underflow}, {7'd0, e_rgb, e_uf});
  endtask

  logic [23:0] cap_p0, cap_p1, cap_x0, cap_out;
  logic [17:0] cap_first_addr, cap_rst_addr;

  task automatic scan_line(input int y, input int grant_pct, input int rst_x);
    for (int x = 0; x < 640; x++) begin
      for (int ph = 0; ph < 2; ph++) begin
        pixel_X_pos  = 10'(x);
        pixel_Y_pos  = 10'(y);
        pixel_strobe = (ph == 0);
        SRAM_grant   = ($urandom_range(0, 99) < grant_pct);
        Reset        = (x == rst_x);
        clk_step();
        if (ph == 0) begin
          if (x == VL)      cap_p0 = {VGA_red, VGA_green, VGA_blue};
          if (x == VL + 1)  cap_p1 = {VGA_red, VGA_green, VGA_blue};
          if (x == 0)       cap_x0 = {VGA_red, VGA_green, VGA_blue};
          if (x == 600)     cap_out = {VGA_red, VGA_green, VGA_blue};
          if (x == rst_x)   cap_rst_addr = SRAM_address;
        end else if (x == VL - 16) begin
          cap_first_addr = SRAM_address;
        end
      end
    end
    Reset = 1'b0;
  endtask

  task automatic do_reset(input int unsigned kind);
    Reset = 1'b1; pixel_strobe = 1'b0; pixel_X_pos = '0; pixel_Y_pos = '0;
    SRAM_grant = 1'b1;
    mem_kind = kind;
    repeat (3) clk_step();
    Reset = 1'b0;
  endtask

  logic [15:0] w_a, w_b;
  logic [17:0] a0;

  initial begin
    VGA_enable = 1'b1; format_mode = 1'b1; SRAM_base_address = '0;
    do_reset(0);
    check("reset_addr", 32'(SRAM_address), 32'd0);
    check("reset_rgb", {8'd0, VGA_red, VGA_green, VGA_blue}, 32'd0);
    check("reset_uf", 32'(underflow), 32'd0);

    // No line start on the top border line: no reads, border is white.
    scan_line(0, 100, -1);
    check("no_issue", 32'(SRAM_address), 32'd0);
    check("top_border", 32'(cap_out), 32'hFFFFFF);

    // RGB565, base 0, word[k] = k
    scan_line(VT - 1, 100, -1);
    check("left_border", 32'(cap_x0), 32'hFFFFFF);
    check("outside_view", 32'(cap_out), 32'h000000);
    scan_line(VT, 100, -1);
    check("565_p0", 32'(cap_p0), 32'h000000);
    check("565_p1", 32'(cap_p1), 32'h000008);
    scan_line(VT + 1, 100, -1);
    check("565_line1_addr", 32'(cap_first_addr), 32'd320);
    check("565_uf", 32'(underflow), 32'd0);

    // Packed RGB24, base 0x100
    format_mode = 1'b0; SRAM_base_address = 18'h100;
    do_reset(1);
    scan_line(VT, 100, -1);
    check("24_p0", 32'(cap_p0), 32'h112233);
    check("24_p1", 32'(cap_p1), 32'h445566);
    scan_line(VT + 1, 100, -1);
    check("24_line1_addr", 32'(cap_first_addr), 32'h100 + 32'd480);
    scan_line(VT + 2, 100, -1);
    check("24_uf", 32'(underflow), 32'd0);

    // Grant withheld for a whole line, then restored
    scan_line(VT + 5, 0, -1);
    check("starved_p0", 32'(cap_p0), 32'h000000);
    check("starved_uf", 32'(underflow), 32'd1);
    scan_line(VT + 6, 100, -1);
    a0  = 18'h100 + 18'(6 * 480);
    w_a = mem_word(1, a0);
    w_b = mem_word(1, a0 + 18'd1);
    check("recover_p0", 32'(cap_p0), 32'({w_a, w_b[15:8]}));
    check("uf_sticky", 32'(underflow), 32'd1);

    // Enable off, bottom border
    VGA_enable = 1'b0;
    scan_line(VT + 7, 100, -1);
    check("disabled_p0", 32'(cap_p0), 32'h3F3F3F);
    check("disabled_x0", 32'(cap_x0), 32'h3F3F3F);
    check("disabled_out", 32'(cap_out), 32'h3F3F3F);
    VGA_enable = 1'b1;
    scan_line(479, 100, -1);
    check("bottom_border", 32'(cap_out), 32'hFFFFFF);

    // Reset mid line 10, line 11 fetched with no history
    format_mode = 1'b1; SRAM_base_address = 18'h40;
    do_reset(0);
    scan_line(VT + 9, 100, -1);
    scan_line(VT + 10, 100, 300);
    check("midreset_addr", 32'(cap_rst_addr), 32'd0);
    scan_line(VT + 11, 100, -1);
    check("post_reset_addr", 32'(cap_first_addr), 32'h40 + 32'd3520);
    check("post_reset_p0", 32'(cap_p0), 32'(rgb565(mem_word(0, 18'h40 + 18'd3520))));

    // Randomized lines: format, base, grant density, enable
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      format_mode       = 1'($urandom_range(0, 1));
      SRAM_base_address = 18'($urandom);
      VGA_enable        = ($urandom_range(0, 9) != 0);
      scan_line(int'($urandom_range(VT - 2, VT + IH + 1)), int'($urandom_range(60, 100)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sram_line_fetcher.md
# vga_sram_line_fetcher

Parametrised VGA pixel source that replaces the fixed 3-words-per-2-pixels SRAM sequencer. It prefetches each image line from SRAM into a small word FIFO, honouring an arbitration grant. It unpacks pixels in one of two formats (packed RGB24 or RGB565) and drives registered RGB to the VGA controller. It sits between the SRAM arbiter and the VGA_controller, in the top-level VGA display path.

## Interface
Parameters:
- IMG_WIDTH, 320, image width in pixels (even).
- IMG_HEIGHT, 240, image height in lines.
- VIEW_LEFT, 160, first displayed pixel_X_pos (≥ 16).
- VIEW_TOP, 120, first displayed pixel_Y_pos.
- SRAM_LATENCY, 2, clocks from SRAM_address driven to SRAM_read_data valid.
- FIFO_DEPTH, 8, word FIFO depth (power of 2, ≥ 4).

Ports:
- Clock  in  1  system clock (50 MHz).
- Reset  in  1  asynchronous, active-high reset.
- VGA_enable  in  1  block enable; 0 forces grey output.
- pixel_strobe  in  1  one-clock 25 MHz pixel enable, aligned with the VGA controller.
- pixel_X_pos, pixel_Y_pos  in  10 each  current scan coordinates.
- format_mode  in  1  0 = packed RGB24, 1 = RGB565; sampled at each line start.
- SRAM_base_address  in  18  word address of image pixel (0,0).
- SRAM_grant  in  1  arbiter permits a read issue this clock.
- SRAM_address  out  18  read address.
- SRAM_read_data  in  16  read data.
- VGA_red, VGA_green, VGA_blue  out  8 each  registered colour.
- underflow  out  1  sticky flag: a pixel was due but the FIFO lacked data.

## Operation
- Words per line: WPL = 3·IMG_WIDTH/2 (RGB24) or IMG_WIDTH (RGB565).
- Line start: pixel_Y_pos in [VIEW_TOP, VIEW_TOP+IMG_HEIGHT) and pixel_X_pos == VIEW_LEFT−16 on a strobe cycle.
  - Flush the FIFO and in-flight tracking.
  - Latch the mode.
  - Load the issue address: SRAM_base_address + (pixel_Y_pos−VIEW_TOP)·WPL, modulo 2^18.
  - Load remaining = WPL.
- States:
  - S_IDLE → S_FETCH at line start.
  - S_FETCH → S_DRAIN when remaining reaches 0.
  - S_DRAIN → S_IDLE when pixel_X_pos ≥ VIEW_LEFT+IMG_WIDTH.
  - A line start seen in any state restarts S_FETCH.
- Issue rule (S_FETCH): a read is issued in a cycle iff SRAM_grant=1 and fifo_count + in_flight < FIFO_DEPTH.
  - On issue: SRAM_address takes the issue address; the address increments; remaining decrements.
  - in_flight is tracked by a SRAM_LATENCY-deep valid shift register; the word is pushed when its valid bit emerges.
- Pixel consumption: on strobe cycles inside the view window.
  - RGB565 (needs 1 word, pops 1): R={w[15:11],w[15:13]}, G={w[10:5],w[10:9]}, B={w[4:0],w[4:2]}.
  - RGB24 even pixel (needs 2 words, pops 1): R=w0[15:8], G=w0[7:0], B=w1[15:8].
  - RGB24 odd pixel (needs 2 words, pops 2): R=w1[7:0], G=w2[15:8], B=w2[7:0], read from head and head+1.
  - Insufficient words: output 0x000000, set underflow, pop nothing.
- Colour priority, highest first:
  - VGA_enable=0 → 0x3F/0x3F/0x3F.
  - Border (X ∈ {0,639} or Y ∈ {0,479}) → 0xFF/0xFF/0xFF.
  - Inside the view window → unpacked pixel.
  - Otherwise → 0.
- Full/empty:
  - The issue rule guarantees no FIFO overflow.
  - Push and pop in the same cycle are legal; count changes by the net amount.
  - Words left over at line end are discarded by the next flush.

## Timing
- Reset values: SRAM_address=0, all RGB=0, underflow=0, FIFO empty, in_flight=0, state S_IDLE.
- RGB updates only at the edge ending a strobe cycle; the value corresponds to that cycle's coordinates (1-clock registered latency).
- SRAM data is captured exactly SRAM_LATENCY clocks after the issuing cycle, regardless of grant in later cycles.
- The prefetch window of 16 pixels (32 clocks) fills FIFO_DEPTH words before the first pixel when grant is continuous.
- Steady-state demand is 0.75 word/clock (RGB24) or 0.5 word/clock (RGB565).
- Reset mid-line: everything clears within the reset; outputs follow the priority rules with an empty FIFO until the next line start. The next line address derives from pixel_Y_pos, so it is correct with no history.
- underflow clears only on Reset.

## Test plan
- Reset → SRAM_address=0, RGB=0x000000, underflow=0; no read issued until a line start.
- RGB565, base 0, SRAM word[k]=k, grant=1, line Y=VIEW_TOP → pixel 0 = 0x000000, pixel 1 = B 0x08 with R=G=0; line 1 first issue address = 320.
- RGB24, base 0x100, words 0x1122, 0x3344, 0x5566 → pixel 0 = 11/22/33, pixel 1 = 44/55/66; line 1 first issue address = 0x100+480; zero underflow across a full frame.
- SRAM_grant=0 for all of line 5, then 1 → line 5 pixels 0x000000, underflow=1 and stays 1; line 6 displays correctly.
- VGA_enable=0 → 0x3F3F3F everywhere; VGA_enable=1, X=0 or Y=479 → 0xFFFFFF; outside the view window → 0x000000.
- Reset pulsed mid line 10 → SRAM_address=0 during reset; line 11 fetched from base+11·WPL with correct pixels.
